// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, oversampling
// factor and the baud-select lookup used to size the sample-tick divider.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'b000,
      START  = 3'b001,
      DATA   = 3'b010,
      PARITY = 3'b011,
      STOP   = 3'b100
   } rxState_e;

   localparam int unsigned OVERSAMPLE = 16;

   function automatic int unsigned baudRate(input logic [2:0] code);
      case (code)
         3'd0:    return 300;
         3'd1:    return 1200;
         3'd2:    return 4800;
         3'd3:    return 9600;
         3'd4:    return 19200;
         3'd5:    return 38400;
         3'd6:    return 57600;
         default: return 115200;
      endcase
   endfunction

   // Clocks per oversample tick, rounded to nearest.
   function automatic int unsigned tickDivisor(input int unsigned clkFreq,
                                               input logic [2:0] code);
      int unsigned den;
      den = OVERSAMPLE * baudRate(code);
      return (clkFreq + den / 2) / den;
   endfunction

endpackage

// File: rtl/rx_sample_tick.sv
// Oversample tick generator: one-clk pulse every round(CLK_FREQ/(16*baud))
// clocks; any change of baud_select restarts the count from zero.
module rx_sample_tick
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 50_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] baud_select,
   output logic       tick
);

   localparam int unsigned MAX_DIV = tickDivisor(CLK_FREQ, 3'd0);
   localparam int unsigned DIV_W   = $clog2(MAX_DIV + 1);

   logic [DIV_W-1:0] divCnt_q, divCnt_d;
   logic [DIV_W-1:0] lastCnt;
   logic [2:0]       sel_q;
   logic             selChanged;

   // The loop only picks between constant divisors; no divider is built.
   always_comb begin
      lastCnt = '0;
      for (int i = 0; i < 8; i++) begin
         if (baud_select == 3'(i)) begin
            lastCnt = DIV_W'(tickDivisor(CLK_FREQ, 3'(i)) - 1);
         end
      end
   end

   assign selChanged = (baud_select != sel_q);
   assign tick       = !selChanged && (divCnt_q == lastCnt);

   always_comb begin
      divCnt_d = divCnt_q + 1'b1;
      if (selChanged || (divCnt_q >= lastCnt)) begin
         divCnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         divCnt_q <= '0;
         sel_q    <= baud_select;
      end else begin
         divCnt_q <= divCnt_d;
         sel_q    <= baud_select;
      end
   end

endmodule

// File: rtl/receiver_uart.sv
// 16x oversampling UART receiver: 8 data bits LSB first, even parity, one
// stop bit; each bit is a 2-of-3 majority vote taken at mid-bit.
module receiver_uart
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 50_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       RxD,
   input  logic [2:0] baud_select,
   input  logic       RX_EN,
   output logic [7:0] Rx_DATA,
   output logic       Rx_VALID,
   output logic       Rx_PERROR,
   output logic       Rx_FERROR
);

   logic       sync1_q, sync2_q, rxs;
   logic       tick;
   rxState_e   state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [2:0] idx_q, idx_d;
   logic [7:0] shreg_q, shreg_d;
   logic       parity_q, parity_d;
   logic       s7_q, s7_d, s8_q, s8_d;
   logic [7:0] data_q, data_d;
   logic       valid_q, valid_d;
   logic       perr_q, perr_d;
   logic       ferr_q, ferr_d;
   logic       vote;

   rx_sample_tick #(.CLK_FREQ(CLK_FREQ)) u_tick (
      .clk         (clk),
      .reset       (reset),
      .baud_select (baud_select),
      .tick        (tick)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= RxD;
         sync2_q <= sync1_q;
      end
   end

   assign rxs  = sync2_q;
   assign vote = (s7_q & s8_q) | (s7_q & rxs) | (s8_q & rxs);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      shreg_d  = shreg_q;
      parity_d = parity_q;
      s7_d     = s7_q;
      s8_d     = s8_q;
      data_d   = data_q;
      valid_d  = 1'b0;
      perr_d   = perr_q;
      ferr_d   = ferr_q;
      if (!RX_EN) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else if (tick) begin
         if (state_q != IDLE) begin
            cnt_d = cnt_q + 4'd1;
         end
         if (cnt_q == 4'd7) s7_d = rxs;
         if (cnt_q == 4'd8) s8_d = rxs;
         // Decisions fall on cnt 9; phase transitions on cnt 15.
         case (state_q)
            IDLE: begin
               if (!rxs) begin
                  state_d = START;
                  cnt_d   = '0;
               end
            end
            START: begin
               if (cnt_q == 4'd9) begin
                  if (vote) begin
                     state_d = IDLE;
                     cnt_d   = '0;
                  end else begin
                     perr_d = 1'b0;
                     ferr_d = 1'b0;
                  end
               end else if (cnt_q == 4'd15) begin
                  state_d = DATA;
                  idx_d   = '0;
               end
            end
            DATA: begin
               if (cnt_q == 4'd9) begin
                  shreg_d[idx_q] = vote;
               end else if (cnt_q == 4'd15) begin
                  if (idx_q == 3'd7) state_d = PARITY;
                  else               idx_d   = idx_q + 3'd1;
               end
            end
            PARITY: begin
               if (cnt_q == 4'd9)       parity_d = vote;
               else if (cnt_q == 4'd15) state_d  = STOP;
            end
            STOP: begin
               if (cnt_q == 4'd9) begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  ferr_d  = !vote;
                  perr_d  = (parity_q != ^shreg_q);
                  if (vote && (parity_q == ^shreg_q)) begin
                     data_d  = shreg_q;
                     valid_d = 1'b1;
                  end
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         shreg_q  <= '0;
         parity_q <= 1'b0;
         s7_q     <= 1'b1;
         s8_q     <= 1'b1;
         data_q   <= 8'h00;
         valid_q  <= 1'b0;
         perr_q   <= 1'b0;
         ferr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         shreg_q  <= shreg_d;
         parity_q <= parity_d;
         s7_q     <= s7_d;
         s8_q     <= s8_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         perr_q   <= perr_d;
         ferr_q   <= ferr_d;
      end
   end

   assign Rx_DATA   = data_q;
   assign Rx_VALID  = valid_q;
   assign Rx_PERROR = perr_q;
   assign Rx_FERROR = ferr_q;

endmodule

// File: tb/tb_receiver_uart.sv
// Scenario bench for receiver_uart at 50 MHz / 115200 baud: frames are driven
// bit-serially and compared with a frame-level model of the expected outputs.
`timescale 1ns/1ps
module tb_receiver_uart;

   localparam int CLK_HALF    = 10;
   localparam int BIT_NS      = 16 * 27 * 2 * CLK_HALF;
   localparam int FAST_BIT_NS = 8388;
   localparam int TICK_NS     = 27 * 2 * CLK_HALF;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       RxD = 1'b1;
   logic       RX_EN = 1'b1;
   logic [2:0] baud_select = 3'b111;
   logic [7:0] Rx_DATA;
   logic       Rx_VALID, Rx_PERROR, Rx_FERROR;

   int         vectors = 0;
   int         miscompares = 0;
   logic [7:0] rxQ[$];
   logic [7:0] expQ[$];
   logic [7:0] expData = 8'h00;
   logic       expPerr = 1'b0;
   logic       expFerr = 1'b0;
   logic       prevValid = 1'b0;

   receiver_uart #(.CLK_FREQ(50_000_000)) dut (
      .clk         (clk),
      .reset       (reset),
      .RxD         (RxD),
      .baud_select (baud_select),
      .RX_EN       (RX_EN),
      .Rx_DATA     (Rx_DATA),
      .Rx_VALID    (Rx_VALID),
      .Rx_PERROR   (Rx_PERROR),
      .Rx_FERROR   (Rx_FERROR)
   );

   always #CLK_HALF clk = ~clk;

   // Collect every accepted byte and flag any valid pulse wider than one clk.
   always @(negedge clk) begin
      if (Rx_VALID) begin
         rxQ.push_back(Rx_DATA);
         vectors++;
         if (prevValid) begin
            miscompares++;
            $display("[TB] FAIL valid_width: got Rx_VALID high 2 cycles, want 1");
         end
      end
      prevValid = Rx_VALID;
   end

   // Frame-level reference: what a complete frame should do to the outputs.
   function automatic void modelFrame(input logic [7:0] data, input logic par, input logic stp);
      expFerr = !stp;
      expPerr = (par != ^data);
      if (stp && (par == ^data)) begin
         expData = data;
         expQ.push_back(data);
      end
   endfunction

   // abortKind: 0 none, 1 drop RX_EN, 2 assert reset, starting mid-bit abortBit.
   task automatic sendFrame(input logic [7:0] data, input logic par, input logic stp,
                            input int bitNs, input int abortBit, input int abortKind);
      logic [10:0] bits;
      bits = {stp, par, data, 1'b0};
      for (int i = 0; i < 11; i++) begin
         RxD = bits[i];
         if ((i == abortBit) && (abortKind != 0)) begin
            #(bitNs / 2);
            @(negedge clk);
            if (abortKind == 1) RX_EN = 1'b0;
            else                reset = 1'b0;
            #(bitNs / 2);
         end else begin
            #(bitNs);
         end
      end
      RxD = 1'b1;
      if (abortKind != 0) begin
         @(negedge clk);
         RX_EN = 1'b1;
         reset = 1'b1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      RxD   = 1'b1;
      repeat (6) @(negedge clk);
      vectors++; if (Rx_DATA !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_data: got %h want 00", Rx_DATA); end
      vectors++; if (Rx_VALID !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b want 0", Rx_VALID); end
      vectors++; if (Rx_PERROR !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_perr: got %b want 0", Rx_PERROR); end
      vectors++; if (Rx_FERROR !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ferr: got %b want 0", Rx_FERROR); end
      reset = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_frame(input string name, input logic [7:0] data, input logic par,
                             input logic stp, input int bitNs);
      logic [7:0] got, want;
      modelFrame(data, par, stp);
      @(negedge clk);
      sendFrame(data, par, stp, bitNs, -1, 0);
      #(BIT_NS);
      @(negedge clk);
      vectors++;
      if (rxQ.size() != expQ.size()) begin
         miscompares++;
         $display("[TB] FAIL %s_count: got %0d pulses want %0d", name, rxQ.size(), expQ.size());
      end
      while ((rxQ.size() > 0) && (expQ.size() > 0)) begin
         got = rxQ.pop_front(); want = expQ.pop_front(); vectors++;
         if (got !== want) begin miscompares++; $display("[TB] FAIL %s_byte: got %h want %h", name, got, want); end
      end
      rxQ.delete(); expQ.delete();
      vectors++; if (Rx_DATA !== expData) begin miscompares++; $display("[TB] FAIL %s_data: got %h want %h", name, Rx_DATA, expData); end
      vectors++; if (Rx_PERROR !== expPerr) begin miscompares++; $display("[TB] FAIL %s_perr: got %b want %b", name, Rx_PERROR, expPerr); end
      vectors++; if (Rx_FERROR !== expFerr) begin miscompares++; $display("[TB] FAIL %s_ferr: got %b want %b", name, Rx_FERROR, expFerr); end
   endtask

   task automatic test_glitch();
      @(negedge clk);
      RxD = 1'b0;
      #(4 * TICK_NS);
      RxD = 1'b1;
      #(12 * TICK_NS);
      @(negedge clk);
      vectors++; if (rxQ.size() != 0) begin miscompares++; $display("[TB] FAIL glitch_count: got %0d pulses want 0", rxQ.size()); end
      rxQ.delete();
      vectors++; if (Rx_DATA !== expData) begin miscompares++; $display("[TB] FAIL glitch_data: got %h want %h", Rx_DATA, expData); end
      vectors++; if (Rx_PERROR !== expPerr) begin miscompares++; $display("[TB] FAIL glitch_perr: got %b want %b", Rx_PERROR, expPerr); end
      vectors++; if (Rx_FERROR !== expFerr) begin miscompares++; $display("[TB] FAIL glitch_ferr: got %b want %b", Rx_FERROR, expFerr); end
      test_frame("after_glitch", 8'h55, ^8'h55, 1'b1, BIT_NS);
   endtask

   task automatic test_back_to_back();
      logic [7:0] bytes [3];
      logic [7:0] got, want;
      bytes = '{8'h00, 8'hFF, 8'h81};
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         modelFrame(bytes[i], ^bytes[i], 1'b1);
         sendFrame(bytes[i], ^bytes[i], 1'b1, FAST_BIT_NS, -1, 0);
      end
      #(BIT_NS);
      @(negedge clk);
      vectors++;
      if (rxQ.size() != expQ.size()) begin
         miscompares++;
         $display("[TB] FAIL b2b_count: got %0d pulses want %0d", rxQ.size(), expQ.size());
      end
      while ((rxQ.size() > 0) && (expQ.size() > 0)) begin
         got = rxQ.pop_front(); want = expQ.pop_front(); vectors++;
         if (got !== want) begin miscompares++; $display("[TB] FAIL b2b_byte: got %h want %h", got, want); end
      end
      rxQ.delete(); expQ.delete();
      vectors++; if (Rx_DATA !== expData) begin miscompares++; $display("[TB] FAIL b2b_data: got %h want %h", Rx_DATA, expData); end
   endtask

   task automatic test_enable_reset();
      @(negedge clk);
      sendFrame(8'hC3, ^8'hC3, 1'b1, BIT_NS, 5, 1);
      #(BIT_NS);
      @(negedge clk);
      vectors++; if (rxQ.size() != 0) begin miscompares++; $display("[TB] FAIL rxen_count: got %0d pulses want 0", rxQ.size()); end
      rxQ.delete();
      vectors++; if (Rx_DATA !== expData) begin miscompares++; $display("[TB] FAIL rxen_data: got %h want %h", Rx_DATA, expData); end
      vectors++; if (Rx_PERROR !== expPerr) begin miscompares++; $display("[TB] FAIL rxen_perr: got %b want %b", Rx_PERROR, expPerr); end
      vectors++; if (Rx_FERROR !== expFerr) begin miscompares++; $display("[TB] FAIL rxen_ferr: got %b want %b", Rx_FERROR, expFerr); end
      sendFrame(8'h96, ^8'h96, 1'b1, BIT_NS, 6, 2);
      expData = 8'h00; expPerr = 1'b0; expFerr = 1'b0;
      #(BIT_NS);
      @(negedge clk);
      vectors++; if (rxQ.size() != 0) begin miscompares++; $display("[TB] FAIL rst_count: got %0d pulses want 0", rxQ.size()); end
      rxQ.delete();
      vectors++; if (Rx_DATA !== 8'h00) begin miscompares++; $display("[TB] FAIL rst_data: got %h want 00", Rx_DATA); end
      vectors++; if (Rx_PERROR !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_perr: got %b want 0", Rx_PERROR); end
      vectors++; if (Rx_FERROR !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_ferr: got %b want 0", Rx_FERROR); end
      test_frame("after_abort", 8'h7E, ^8'h7E, 1'b1, BIT_NS);
   endtask

   task automatic test_random();
      logic [7:0] data;
      int         kind;
      for (int i = 0; i < 3; i++) begin
         data = 8'($urandom);
         kind = int'($urandom_range(0, 3));
         test_frame("random", data, (^data) ^ (kind == 0), (kind != 1), BIT_NS);
         #($urandom_range(0, BIT_NS));
      end
   endtask

   initial begin
      $display("[TB] receiver_uart bench start");
      test_reset();
      test_frame("a5", 8'hA5, 1'b0, 1'b1, BIT_NS);
      test_frame("bad_parity", 8'h3C, 1'b1, 1'b1, BIT_NS);
      test_frame("good_01", 8'h01, 1'b1, 1'b1, BIT_NS);
      test_frame("bad_stop", 8'hFF, 1'b0, 1'b0, BIT_NS);
      test_glitch();
      test_back_to_back();
      test_enable_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
